regfile_alu: RTL and testbench

- Execute stage directly downstream of the fetch/decode top.
- Consumes the fetched instruction word, sign-extended immediate and control strobes (RegWrite, ALUctrl, ALUsrc).
- Produces the EQ flag that control uses to resolve branches, and exposes architectural register x10 (a0) as the program's observable result.
- Contains a 32-entry register file with synchronous write, combinational reads, a 1-bit-select ALU and a retired-write counter.

---
 rtl/regfile_alu.sv | 75 +++++++
 tb/tb_regfile_alu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu.sv
// Execute stage: 32-entry register file, add/sub ALU and retired-write counter.
// Define REGFILE_DEBUG_PORT_EN to add a third read port (dbg_addr/dbg_data).
module regfile_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  RegWrite,
  input  logic                  ALUsrc,
  input  logic                  ALUctrl,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_BITS-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  output logic                  EQ,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [31:0]           wr_count
);

  localparam int NREG = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [31:0]           wr_count_q;
  logic [31:0]           wr_count_d;

  logic [ADDR_BITS-1:0]  rs1;
  logic [ADDR_BITS-1:0]  rs2;
  logic [ADDR_BITS-1:0]  rd;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  we;
  logic                  unused_instr;

  assign rs1 = instr[15 +: ADDR_BITS];
  assign rs2 = instr[20 +: ADDR_BITS];
  assign rd  = instr[7 +: ADDR_BITS];

  // Opcode/funct bits are decoded upstream; only register fields matter here.
  assign unused_instr = ^{instr[31:25], instr[14:12], instr[6:0]};

  assign rd1 = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rd2 = (rs2 == '0) ? '0 : regs_q[rs2];

  assign op_b   = ALUsrc ? ImmOp : rd2;
  assign ALUout = ALUctrl ? (rd1 - op_b) : (rd1 + op_b);
  assign EQ     = (rd1 == rd2);

  assign we         = RegWrite && (rd != '0);
  assign wr_count_d = wr_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (we) begin
      regs_q[rd] <= ALUout;
      wr_count_q <= wr_count_d;
    end
  end

  assign a0       = regs_q[10];
  assign wr_count = wr_count_q;

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_alu.sv
// Directed self-checking bench for regfile_alu.
// Inputs change on the falling edge; outputs are checked away from posedge.
module tb_regfile_alu;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] ImmOp;
  logic        RegWrite;
  logic        ALUsrc;
  logic        ALUctrl;
  logic        EQ;
  logic [31:0] ALUout;
  logic [31:0] a0;
  logic [31:0] wr_count;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt;

  regfile_alu dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .ImmOp    (ImmOp),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .ALUctrl  (ALUctrl),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
`endif
    .EQ       (EQ),
    .ALUout   (ALUout),
    .a0       (a0),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] imm,
                       input logic we, input logic src, input logic sub);
    instr    = ins;
    ImmOp    = imm;
    RegWrite = we;
    ALUsrc   = src;
    ALUctrl  = sub;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(mk(5'd10, 5'd0, 5'd0), 32'd5, 1'b1, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    drive(mk(5'd0, 5'd0, 5'd0), 32'd5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (a0 !== 32'd0) begin
      errors++; $display("FAIL reset_a0 got=%h exp=%h", a0, 32'd0);
    end
    checks++;
    if (wr_count !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%h exp=%h", wr_count, 32'd0);
    end
    checks++;
    if (EQ !== 1'b1) begin
      errors++; $display("FAIL reset_eq got=%b exp=1", EQ);
    end
    checks++;
    if (ALUout !== 32'd5) begin
      errors++; $display("FAIL reset_aluout got=%h exp=%h", ALUout, 32'd5);
    end
    exp_cnt = 32'd0;
  endtask

  task automatic test_addi();
    drive(mk(5'd10, 5'd0, 5'd0), 32'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ALUout !== 32'd5) begin
      errors++; $display("FAIL addi_alu got=%h exp=%h", ALUout, 32'd5);
    end
    checks++;
    if (a0 !== 32'd0) begin
      errors++; $display("FAIL addi_a0_old got=%h exp=%h", a0, 32'd0);
    end
    step();
    exp_cnt++;
    drive(mk(5'd0, 5'd0, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (a0 !== 32'd5) begin
      errors++; $display("FAIL addi_a0 got=%h exp=%h", a0, 32'd5);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL addi_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_x0_write();
    drive(mk(5'd0, 5'd0, 5'd0), 32'hFF, 1'b1, 1'b1, 1'b0);
    step();
    drive(mk(5'd0, 5'd0, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ALUout !== 32'd0) begin
      errors++; $display("FAIL x0_alu got=%h exp=%h", ALUout, 32'd0);
    end
    checks++;
    if (EQ !== 1'b1) begin
      errors++; $display("FAIL x0_eq got=%b exp=1", EQ);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL x0_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_sub_wrap();
    drive(mk(5'd2, 5'd1, 5'd0), 32'd1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ALUout !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_alu got=%h exp=%h", ALUout, 32'hFFFF_FFFF);
    end
    step();
    exp_cnt++;
    drive(mk(5'd0, 5'd2, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ALUout !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_x2 got=%h exp=%h", ALUout, 32'hFFFF_FFFF);
    end
    drive(mk(5'd1, 5'd0, 5'd0), 32'd3, 1'b1, 1'b1, 1'b0);
    step();
    drive(mk(5'd2, 5'd0, 5'd0), 32'd3, 1'b1, 1'b1, 1'b0);
    step();
    exp_cnt += 2;
    drive(mk(5'd0, 5'd1, 5'd2), 32'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (EQ !== 1'b1) begin
      errors++; $display("FAIL eq_33 got=%b exp=1", EQ);
    end
    checks++;
    if (ALUout !== 32'd0) begin
      errors++; $display("FAIL sub_rr got=%h exp=%h", ALUout, 32'd0);
    end
    // x2 <= x1 + 1 while reading x2: EQ must still see the old 3
    drive(mk(5'd2, 5'd1, 5'd2), 32'd1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (EQ !== 1'b1) begin
      errors++; $display("FAIL rdw_old got=%b exp=1", EQ);
    end
    step();
    exp_cnt++;
    drive(mk(5'd0, 5'd1, 5'd2), 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (EQ !== 1'b0) begin
      errors++; $display("FAIL eq_34 got=%b exp=0", EQ);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL sub_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_countdown();
    logic [31:0] exp_a0;
    drive(mk(5'd10, 5'd0, 5'd0), 32'd3, 1'b1, 1'b1, 1'b0);
    step();
    exp_cnt++;
    exp_a0 = 32'd3;
    drive(mk(5'd10, 5'd10, 5'd0), 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (EQ !== 1'b0) begin
        errors++; $display("FAIL loop_eq%0d got=%b exp=0", i, EQ);
      end
      step();
      exp_cnt++;
      exp_a0 = exp_a0 - 32'd1;
      checks++;
      if (a0 !== exp_a0) begin
        errors++; $display("FAIL loop_a0_%0d got=%h exp=%h", i, a0, exp_a0);
      end
    end
    drive(mk(5'd0, 5'd10, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (EQ !== 1'b1) begin
      errors++; $display("FAIL loop_eq_end got=%b exp=1", EQ);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL loop_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_midrun_reset();
    drive(mk(5'd5, 5'd0, 5'd0), 32'd7, 1'b1, 1'b1, 1'b0);
    step();
    drive(mk(5'd0, 5'd5, 5'd0), 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ALUout !== 32'd7) begin
      errors++; $display("FAIL mid_x5 got=%h exp=%h", ALUout, 32'd7);
    end
    rst = 1'b0;
    drive(mk(5'd5, 5'd0, 5'd0), 32'd9, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    exp_cnt = 32'd0;
    drive(mk(5'd0, 5'd5, 5'd0), 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ALUout !== 32'd0) begin
      errors++; $display("FAIL mid_x5_clr got=%h exp=%h", ALUout, 32'd0);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL mid_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
    checks++;
    if (a0 !== 32'd0) begin
      errors++; $display("FAIL mid_a0 got=%h exp=%h", a0, 32'd0);
    end
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      errors++; $display("FAIL mid_dbg got=%h exp=%h", dbg_data, 32'd0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive(mk(5'd3, 5'd0, 5'd0), 32'd1, 1'b1, 1'b1, 1'b0);
    step();
    drive(mk(5'd4, 5'd3, 5'd3), 32'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ALUout !== 32'd2) begin
      errors++; $display("FAIL b2b_alu got=%h exp=%h", ALUout, 32'd2);
    end
    step();
    exp_cnt += 2;
    drive(mk(5'd0, 5'd4, 5'd0), 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ALUout !== 32'd2) begin
      errors++; $display("FAIL b2b_x4 got=%h exp=%h", ALUout, 32'd2);
    end
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 32'd2) begin
      errors++; $display("FAIL b2b_dbg got=%h exp=%h", dbg_data, 32'd2);
    end
`endif
    checks++;
    if (wr_count !== exp_cnt) begin
      errors++; $display("FAIL b2b_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  initial begin
    rst      = 1'b0;
    instr    = '0;
    ImmOp    = '0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 1'b0;
    exp_cnt  = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = '0;
`endif
    @(negedge clk);
    test_reset();
    test_addi();
    test_x0_write();
    test_sub_wrap();
    test_countdown();
    test_midrun_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
